// File: rtl/mixn_tdm.sv
// N-channel time-multiplexed complex down-mixer: one channel per cycle through a shared
// quarter-wave sin/cos table and one multiplier pair, emitting a channel-tagged I/Q stream.
`timescale 1ns/1ps
module mixn_tdm #(
    parameter int NCH     = 4,
    parameter int ADCW    = 12,
    parameter int PHW     = 32,
    parameter int LUTBITS = 10,
    parameter int SINW    = 18,
    parameter int OUTW    = 18,
    parameter int SHIFT   = 11
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [NCH*ADCW-1:0]                   adc,
    input  logic [NCH*PHW-1:0]                    phi,
    input  logic [NCH-1:0]                        chan_en,
    input  logic                                  phase_clr,
    input  logic                                  overrun_clr,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_chan,
    output logic signed [OUTW-1:0]                out_i,
    output logic signed [OUTW-1:0]                out_q,
    output logic                                  out_sat,
    output logic                                  overrun
);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = ADCW + SINW;
    localparam int TBL = 2 ** LUTBITS;
    localparam logic signed [PW:0] RND  = (PW+1)'(2 ** (SHIFT - 1));
    localparam logic signed [PW:0] OMAX = (PW+1)'(2 ** (OUTW - 1) - 1);
    localparam logic signed [PW:0] OMIN = -OMAX - 1;

    typedef enum logic {IDLE, RUN} state_t;

    // Half-step offset keeps every entry strictly between zero and full scale.
    function automatic logic signed [SINW-1:0] lut_entry(input int i);
        real x;
        x = real'(2 ** (SINW - 1) - 1) *
            $sin((real'(i) + 0.5) * 3.14159265358979323846 / real'(2 ** (LUTBITS + 1)));
        return SINW'($rtoi(x + 0.5));
    endfunction

    function automatic logic [OUTW:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] r;
        r = (PW+1)'(p) + RND;
        r = r >>> SHIFT;
        if (r > OMAX) return {1'b1, OMAX[OUTW-1:0]};
        if (r < OMIN) return {1'b1, OMIN[OUTW-1:0]};
        return {1'b0, r[OUTW-1:0]};
    endfunction

    logic signed [SINW-1:0] lut [TBL];
    for (genvar g = 0; g < TBL; g++) begin : g_lut
        localparam logic signed [SINW-1:0] V = lut_entry(g);
        assign lut[g] = V;
    end

    state_t               state_q;
    logic [CW-1:0]        slot_q;
    logic [NCH*ADCW-1:0]  adc_q;
    logic [PHW-1:0]       acc_q [NCH];
    logic [PHW-1:0]       ph_cur;
    logic                 en_cur;

    logic                   v1_q, v2_q, v3_q;
    logic [CW-1:0]          ch1_q, ch2_q, ch3_q;
    logic [1:0]             quad1_q;
    logic [LUTBITS-1:0]     idx1_q, idx_inv;
    logic signed [ADCW-1:0] smp1_q, smp2_q;
    logic signed [SINW-1:0] s_mag, c_mag, sin2_q, cos2_q;
    logic signed [PW-1:0]   pi3_q, pq3_q;
    logic [OUTW:0]          ri, rq;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            busy    <= 1'b0;
            adc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    adc_q   <= adc;
                    slot_q  <= '0;
                    state_q <= RUN;
                    busy    <= 1'b1;
                end
                RUN: if (slot_q == CW'(NCH - 1)) begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end else begin
                    slot_q <= slot_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A set presented while busy is dropped; a coincident clear loses to the new overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    overrun <= 1'b0;
        else if (in_valid && busy)   overrun <= 1'b1;
        else if (overrun_clr)        overrun <= 1'b0;
    end

    // NOTE: defaults are assigned on every path of combinational blocks, so no latch can form.
    always_comb begin
        ph_cur = acc_q[slot_q];
        en_cur = chan_en[slot_q];
    end

    // NOTE: the accumulators form a small register array that must restart at phase 0, so it is reset; the LUT is constant and needs none.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
        end else if (phase_clr) begin
            for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
        end else if (state_q == RUN) begin
            acc_q[slot_q] <= en_cur ? ph_cur + phi[int'(slot_q) * PHW +: PHW] : '0;
        end
    end

    always_comb begin
        idx_inv = ~idx1_q;
        s_mag   = quad1_q[0] ? lut[idx_inv] : lut[idx1_q];
        c_mag   = quad1_q[0] ? lut[idx1_q]  : lut[idx_inv];
        ri      = round_sat(pi3_q);
        rq      = round_sat(pq3_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            ch1_q <= '0; ch2_q <= '0; ch3_q <= '0;
            quad1_q <= '0; idx1_q <= '0; smp1_q <= '0; smp2_q <= '0;
            sin2_q <= '0; cos2_q <= '0; pi3_q <= '0; pq3_q <= '0;
            out_valid <= 1'b0; out_chan <= '0;
            out_i <= '0; out_q <= '0; out_sat <= 1'b0;
        end else begin
            v1_q    <= (state_q == RUN);
            ch1_q   <= slot_q;
            quad1_q <= ph_cur[PHW-1 -: 2];
            idx1_q  <= ph_cur[PHW-3 -: LUTBITS];
            smp1_q  <= en_cur ? adc_q[int'(slot_q) * ADCW +: ADCW] : '0;

            v2_q   <= v1_q;
            ch2_q  <= ch1_q;
            smp2_q <= smp1_q;
            sin2_q <= quad1_q[1] ? -s_mag : s_mag;
            cos2_q <= (quad1_q[1] ^ quad1_q[0]) ? -c_mag : c_mag;

            v3_q  <= v2_q;
            ch3_q <= ch2_q;
            pi3_q <= PW'(smp2_q) * PW'(cos2_q);
            pq3_q <= PW'(smp2_q) * PW'(sin2_q);

            out_valid <= v3_q;
            if (v3_q) begin
                out_chan <= ch3_q;
                out_i    <= ri[OUTW-1:0];
                out_q    <= rq[OUTW-1:0];
                out_sat  <= ri[OUTW] | rq[OUTW];
            end
        end
    end
endmodule

// File: tb/tb_mixn_tdm.sv
// Scoreboard bench for mixn_tdm: an independent trig model predicts each I/Q beat and its cycle,
// checked for a default instance and a SHIFT=10 instance driven in parallel.
`timescale 1ns/1ps
module tb_mixn_tdm;
    localparam int NCH = 4, ADCW = 12, PHW = 32, OUTW = 18;

    typedef struct {
        int cyc;
        int ch;
        int i;
        int q;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, phase_clr, overrun_clr;
    logic [NCH*ADCW-1:0] adc;
    logic [NCH*PHW-1:0]  phi;
    logic [NCH-1:0]      chan_en;

    logic busy, out_valid, out_sat, overrun;
    logic [1:0] out_chan;
    logic signed [OUTW-1:0] out_i, out_q;
    logic s_busy, s_valid, s_sat, s_overrun;
    logic [1:0] s_chan;
    logic signed [OUTW-1:0] s_i, s_q;

    int adc_v [NCH];
    logic [31:0] phi_v [NCH];
    logic [31:0] macc [NCH];
    exp_t sb [$];
    exp_t sb_s [$];
    int cyc = 0;
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            adc[k*ADCW +: ADCW] = ADCW'(adc_v[k]);
            phi[k*PHW +: PHW]   = phi_v[k];
        end
    end

    mixn_tdm u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .adc(adc), .phi(phi), .chan_en(chan_en),
        .phase_clr(phase_clr), .overrun_clr(overrun_clr), .busy(busy), .out_valid(out_valid),
        .out_chan(out_chan), .out_i(out_i), .out_q(out_q), .out_sat(out_sat), .overrun(overrun)
    );

    mixn_tdm #(.SHIFT(10)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .adc(adc), .phi(phi), .chan_en(chan_en),
        .phase_clr(phase_clr), .overrun_clr(overrun_clr), .busy(s_busy), .out_valid(s_valid),
        .out_chan(s_chan), .out_i(s_i), .out_q(s_q), .out_sat(s_sat), .overrun(s_overrun)
    );

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Direct trig at the quantised phase (top 12 bits, half-step centred), not a quadrant fold.
    function automatic void model(input int a, input logic [31:0] p, input int sh, output exp_t e);
        int n;
        real ang;
        longint s, c, ri, rq;
        n   = int'(p[31:20]);
        ang = (real'(n) + 0.5) * 3.141592653589793 / 2048.0;
        s   = longint'(rnd(131071.0 * $sin(ang)));
        c   = longint'(rnd(131071.0 * $cos(ang)));
        ri  = (longint'(a) * c + (longint'(1) << (sh - 1))) >>> sh;
        rq  = (longint'(a) * s + (longint'(1) << (sh - 1))) >>> sh;
        e.sat = 1'b0;
        if (ri > 131071)  begin ri = 131071;  e.sat = 1'b1; end
        if (ri < -131072) begin ri = -131072; e.sat = 1'b1; end
        if (rq > 131071)  begin rq = 131071;  e.sat = 1'b1; end
        if (rq < -131072) begin rq = -131072; e.sat = 1'b1; end
        e.i = int'(ri);
        e.q = int'(rq);
    endfunction

    task automatic push_set(input int t);
        exp_t e, es;
        int a;
        for (int k = 0; k < NCH; k++) begin
            a = chan_en[k] ? adc_v[k] : 0;
            model(a, macc[k], 11, e);
            model(a, macc[k], 10, es);
            e.cyc = t + 5 + k;  e.ch = k;
            es.cyc = t + 5 + k; es.ch = k;
            sb.push_back(e);
            sb_s.push_back(es);
            macc[k] = chan_en[k] ? macc[k] + phi_v[k] : 32'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit clr);
        in_valid  = 1'b1;
        phase_clr = clr;
        if (clr) for (int k = 0; k < NCH; k++) macc[k] = 32'd0;
        push_set(cyc);
        tick();
        in_valid  = 1'b0;
        phase_clr = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (sb.size() == 0 && sb_s.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (2) tick();
    endtask

    task automatic set_all(input int a, input logic [31:0] p, input logic [NCH-1:0] en);
        for (int k = 0; k < NCH; k++) begin
            adc_v[k] = a;
            phi_v[k] = p;
        end
        chan_en = en;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_mis++;
                $display("FAIL main_unexpected: chan %0d i %0d q %0d at cycle %0d, no beat expected",
                         out_chan, out_i, out_q, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || int'(out_chan) != e.ch || int'(out_i) != e.i ||
                    int'(out_q) != e.q || out_sat !== e.sat) begin
                    n_mis++;
                    $display("FAIL main_beat: got cyc %0d ch %0d i %0d q %0d sat %0b, want cyc %0d ch %0d i %0d q %0d sat %0b",
                             cyc, out_chan, out_i, out_q, out_sat, e.cyc, e.ch, e.i, e.q, e.sat);
                end
            end
        end
        if (s_valid === 1'b1) begin
            n_cmp++;
            if (sb_s.size() == 0) begin
                n_mis++;
                $display("FAIL sat_unexpected: chan %0d i %0d q %0d at cycle %0d, no beat expected",
                         s_chan, s_i, s_q, cyc);
            end else begin
                e = sb_s.pop_front();
                if (cyc != e.cyc || int'(s_chan) != e.ch || int'(s_i) != e.i ||
                    int'(s_q) != e.q || s_sat !== e.sat) begin
                    n_mis++;
                    $display("FAIL sat_beat: got cyc %0d ch %0d i %0d q %0d sat %0b, want cyc %0d ch %0d i %0d q %0d sat %0b",
                             cyc, s_chan, s_i, s_q, s_sat, e.cyc, e.ch, e.i, e.q, e.sat);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp += 7;
        if (busy !== 1'b0)      begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (out_chan !== 2'd0)  begin n_mis++; $display("FAIL rst_chan: got %0d want 0", out_chan); end
        if (out_i !== '0)       begin n_mis++; $display("FAIL rst_i: got %0d want 0", out_i); end
        if (out_q !== '0)       begin n_mis++; $display("FAIL rst_q: got %0d want 0", out_q); end
        if (out_sat !== 1'b0)   begin n_mis++; $display("FAIL rst_sat: got %b want 0", out_sat); end
        if (overrun !== 1'b0)   begin n_mis++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        tick();
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        bit ok;
        set_all(1000, 32'd0, 4'hF);
        send(1'b0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== (j <= 4)) begin
                n_mis++;
                $display("FAIL basic_busy T+%0d: got %b want %b", j, busy, (j <= 4));
            end
            tick();
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL basic_drain: %0d beats missing, want 0", sb.size()); end
    endtask

    task automatic test_rotate();
        bit ok;
        set_all(1000, 32'd0, 4'hF);
        phi_v[0] = 32'h4000_0000;
        for (int s = 0; s < 5; s++) begin
            send(1'b0);
            repeat (5) tick();
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL rotate_drain: %0d beats missing, want 0", sb.size()); end
    endtask

    task automatic test_chan_en();
        bit ok;
        set_all(1000, 32'h4000_0000, 4'b1011);
        send(1'b0);
        repeat (4) tick();
        send(1'b0);
        repeat (5) tick();
        chan_en = 4'hF;
        send(1'b0);
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL chan_en_drain: %0d beats missing, want 0", sb.size()); end
    endtask

    task automatic test_phase_clr();
        bit ok;
        set_all(-700, 32'h2345_6789, 4'hF);
        send(1'b0);
        repeat (5) tick();
        phase_clr = 1'b1;
        for (int k = 0; k < NCH; k++) macc[k] = 32'd0;
        tick();
        phase_clr = 1'b0;
        send(1'b0);
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL phase_clr_drain: %0d beats missing, want 0", sb.size()); end
    endtask

    task automatic test_overrun();
        bit ok;
        set_all(321, 32'h1000_0000, 4'hF);
        send(1'b0);
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1) begin n_mis++; $display("FAIL overrun_set: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0) begin n_mis++; $display("FAIL overrun_clr: got %b want 0", overrun); end
        tick();
        send(1'b0);
        in_valid    = 1'b1;
        overrun_clr = 1'b1;
        tick();
        in_valid    = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1) begin n_mis++; $display("FAIL overrun_set_wins: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1) begin n_mis++; $display("FAIL overrun_last_slot: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL overrun_drain: %0d beats missing, want 0", sb.size()); end
    endtask

    task automatic test_sat();
        bit ok;
        set_all(0, 32'd0, 4'hF);
        adc_v[0] = 2047;  adc_v[1] = -2048;
        adc_v[2] = 1;     adc_v[3] = -1;
        send(1'b1);
        repeat (5) tick();
        adc_v[0] = -2048; adc_v[1] = 2047;
        send(1'b0);
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL sat_drain: %0d beats missing, want 0", sb_s.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_all(1000, 32'h4000_0000, 4'hF);
        send(1'b0);
        repeat (2) tick();
        rst = 1'b0;
        sb.delete();
        sb_s.delete();
        for (int k = 0; k < NCH; k++) macc[k] = 32'd0;
        #2;
        n_cmp += 3;
        if (busy !== 1'b0)      begin n_mis++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (overrun !== 1'b0)   begin n_mis++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
        repeat (2) tick();
        rst = 1'b1;
        repeat (8) tick();
        send(1'b0);
        drain(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL mid_rst_drain: %0d beats missing, want 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        phase_clr = 1'b0;
        overrun_clr = 1'b0;
        for (int k = 0; k < NCH; k++) macc[k] = 32'd0;
        set_all(0, 32'd0, 4'hF);
        test_reset();
        test_basic();
        test_rotate();
        test_chan_en();
        test_phase_clr();
        test_overrun();
        test_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end
endmodule
